// File: rtl/idli_pkg.sv
// Shared types for the idli core: predicate registers and comparison ops.
// Operands are processed serially, one NIB_W-bit nibble per cycle.
package idli_pkg;

    localparam int NIB_W = 4;
    localparam int NIB_N = 4;

    typedef enum logic [1:0] {
        PREG_P0,
        PREG_P1,
        PREG_P2,
        PREG_PT
    } preg_t;

    typedef enum logic [2:0] {
        CMP_EQ,
        CMP_NE,
        CMP_LT,
        CMP_GE,
        CMP_LTU,
        CMP_GEU,
        CMP_ANY,
        CMP_NONE
    } cmp_op_t;

    typedef enum logic {
        CMP_ST_IDLE,
        CMP_ST_BUSY
    } cmp_st_t;

    // c is the carry out of A + ~B + 1, i.e. set when A >= B unsigned.
    function automatic logic cmp_result(
        cmp_op_t op,
        logic    diff,
        logic    c,
        logic    as,
        logic    bs,
        logic    any
    );
        logic lt;
        lt = (as != bs) ? as : !c;
        unique case (op)
            CMP_EQ:   return !diff;
            CMP_NE:   return diff;
            CMP_LT:   return lt;
            CMP_GE:   return !lt;
            CMP_LTU:  return !c;
            CMP_GEU:  return c;
            CMP_ANY:  return any;
            CMP_NONE: return !any;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/idli_cmp_m_if.sv
// Nibble-serial operand bus into the compare unit and the predicate
// write port it drives.
interface idli_cmp_m_if;
    import idli_pkg::*;

    logic               i_cmp_valid;
    logic               i_cmp_start;
    cmp_op_t            i_cmp_op;
    preg_t              i_cmp_pd;
    logic [NIB_W-1:0]   i_cmp_a;
    logic [NIB_W-1:0]   i_cmp_b;
    logic               o_cmp_busy;
    preg_t              o_pred_wr;
    logic               o_pred_wr_en;
    logic               o_pred_wr_data;

    modport master (
        output i_cmp_valid, i_cmp_start, i_cmp_op, i_cmp_pd,
        output i_cmp_a, i_cmp_b,
        input  o_cmp_busy, o_pred_wr, o_pred_wr_en, o_pred_wr_data
    );

    modport slave (
        input  i_cmp_valid, i_cmp_start, i_cmp_op, i_cmp_pd,
        input  i_cmp_a, i_cmp_b,
        output o_cmp_busy, o_pred_wr, o_pred_wr_en, o_pred_wr_data
    );

endinterface

// File: rtl/idli_cmp_nib_m.sv
// One nibble of the serial compare: carry of A + ~B + cin, plus
// "any bit differs" and "any bit common" flags.
module idli_cmp_nib_m
    import idli_pkg::*;
(
    input  logic [NIB_W-1:0] a_i,
    input  logic [NIB_W-1:0] b_i,
    input  logic             cin_i,
    output logic             cout_o,
    output logic             diff_o,
    output logic             any_o
);

    assign cout_o = 1'(({1'b0, a_i} + {1'b0, ~b_i}
                       + {{NIB_W{1'b0}}, cin_i}) >> NIB_W);
    assign diff_o = |(a_i ^ b_i);
    assign any_o  = |(a_i & b_i);

endmodule

// File: rtl/idli_cmp_m.sv
// Bit-serial comparator: consumes four nibbles, then writes one
// predicate result to the predicate register file.
module idli_cmp_m
    import idli_pkg::*;
(
    input  logic         i_cmp_gck,
    input  logic         i_cmp_rst_n,
    idli_cmp_m_if.slave  cmp_if
);

    cmp_st_t    st_q, st_d;
    logic [1:0] cnt_q, cnt_d;
    logic       carry_q, carry_d;
    logic       diff_q, diff_d;
    logic       and_q, and_d;
    cmp_op_t    op_q, op_d;
    preg_t      pd_q, pd_d;
    preg_t      wr_q, wr_d;
    logic       wr_en_q, wr_en_d;
    logic       data_q, data_d;

    logic acc0, accn;
    logic nib_cin, nib_cout, nib_diff, nib_any;
    logic diff_n, and_n;

    assign acc0 = cmp_if.i_cmp_valid && cmp_if.i_cmp_start;
    assign accn = cmp_if.i_cmp_valid && !cmp_if.i_cmp_start
                  && (st_q == CMP_ST_BUSY);

    // Nibble 0 starts a fresh subtraction and fresh flags.
    assign nib_cin = acc0 ? 1'b1 : carry_q;
    assign diff_n  = nib_diff | (!acc0 && diff_q);
    assign and_n   = nib_any | (!acc0 && and_q);

    idli_cmp_nib_m u_nib (
        .a_i    (cmp_if.i_cmp_a),
        .b_i    (cmp_if.i_cmp_b),
        .cin_i  (nib_cin),
        .cout_o (nib_cout),
        .diff_o (nib_diff),
        .any_o  (nib_any)
    );

    always_comb begin
        st_d    = st_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        diff_d  = diff_q;
        and_d   = and_q;
        op_d    = op_q;
        pd_d    = pd_q;
        wr_d    = wr_q;
        wr_en_d = 1'b0;
        data_d  = data_q;
        if (acc0) begin
            st_d    = CMP_ST_BUSY;
            cnt_d   = 2'd1;
            op_d    = cmp_if.i_cmp_op;
            pd_d    = cmp_if.i_cmp_pd;
            carry_d = nib_cout;
            diff_d  = diff_n;
            and_d   = and_n;
        end else if (accn) begin
            cnt_d   = cnt_q + 2'd1;
            carry_d = nib_cout;
            diff_d  = diff_n;
            and_d   = and_n;
            if (cnt_q == 2'd3) begin
                st_d    = CMP_ST_IDLE;
                wr_en_d = (pd_q != PREG_PT);
                wr_d    = pd_q;
                data_d  = cmp_result(op_q, diff_n, nib_cout,
                                     cmp_if.i_cmp_a[NIB_W-1],
                                     cmp_if.i_cmp_b[NIB_W-1], and_n);
            end
        end
    end

    always_ff @(posedge i_cmp_gck or negedge i_cmp_rst_n) begin
        if (!i_cmp_rst_n) begin
            st_q    <= CMP_ST_IDLE;
            cnt_q   <= 2'd0;
            carry_q <= 1'b0;
            diff_q  <= 1'b0;
            and_q   <= 1'b0;
            op_q    <= CMP_EQ;
            pd_q    <= PREG_P0;
            wr_q    <= PREG_P0;
            wr_en_q <= 1'b0;
            data_q  <= 1'b0;
        end else begin
            st_q    <= st_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            diff_q  <= diff_d;
            and_q   <= and_d;
            op_q    <= op_d;
            pd_q    <= pd_d;
            wr_q    <= wr_d;
            wr_en_q <= wr_en_d;
            data_q  <= data_d;
        end
    end

    assign cmp_if.o_cmp_busy     = (st_q == CMP_ST_BUSY);
    assign cmp_if.o_pred_wr      = wr_q;
    assign cmp_if.o_pred_wr_en   = wr_en_q;
    assign cmp_if.o_pred_wr_data = data_q;

endmodule
